// File: rtl/acl2_measurement_text_formatter.sv
// rtl/acl2_measurement_text_formatter.sv - ACL2 snapshot to ASCII hex text line streamer
module acl2_measurement_text_formatter #(
    parameter bit parm_crlf = 1'b1
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rst_20mhz,
    input  logic [63:0] i_data_3axis_temp,
    input  logic        i_data_valid,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_line_done,
    output logic [7:0]  o_drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } t_state;

    localparam logic [4:0] c_last_idx = parm_crlf ? 5'd28 : 5'd27;

    t_state      state;
    t_state      state_nxt;
    logic [63:0] line_reg;
    logic [63:0] pend_reg;
    logic        pend_full;
    logic [4:0]  idx;
    logic [7:0]  drop_count;
    logic        tx_hs;
    logic        take_pend;
    logic        take_new;

    assign tx_hs     = (state == ST_SEND) && i_tx_ready;
    assign take_new  = (state == ST_IDLE) && i_data_valid;
    // A sample parked while the last line finished is picked up from idle too.
    assign take_pend = pend_full &&
                       ((state == ST_DONE) || ((state == ST_IDLE) && !i_data_valid));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_data_valid || pend_full) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (tx_hs && (idx == c_last_idx)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = pend_full ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state      <= ST_IDLE;
            line_reg   <= '0;
            pend_reg   <= '0;
            pend_full  <= 1'b0;
            idx        <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;

            if (take_new) begin
                line_reg <= i_data_3axis_temp;
            end else if (take_pend) begin
                line_reg <= pend_reg;
            end

            if (state == ST_LOAD) begin
                idx <= '0;
            end else if (tx_hs && (idx != c_last_idx)) begin
                idx <= idx + 5'd1;
            end

            if (i_data_valid && (state != ST_IDLE)) begin
                pend_reg  <= i_data_3axis_temp;
                pend_full <= 1'b1;
                if (pend_full && !take_pend && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (take_pend) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Character generator: four 7-character groups "L:hhhh " (last without space), then line end.
    logic [1:0]  grp;
    logic [4:0]  pos;
    logic [15:0] word;
    logic [7:0]  letter;
    logic [3:0]  nib;
    logic [7:0]  tx_char;

    always_comb begin
        grp = 2'd0;
        pos = idx;
        if (idx >= 5'd21) begin
            grp = 2'd3;
            pos = idx - 5'd21;
        end else if (idx >= 5'd14) begin
            grp = 2'd2;
            pos = idx - 5'd14;
        end else if (idx >= 5'd7) begin
            grp = 2'd1;
            pos = idx - 5'd7;
        end

        case (grp)
            2'd0:    begin word = {line_reg[55:48], line_reg[63:56]}; letter = 8'h58; end
            2'd1:    begin word = {line_reg[39:32], line_reg[47:40]}; letter = 8'h59; end
            2'd2:    begin word = {line_reg[23:16], line_reg[31:24]}; letter = 8'h5A; end
            default: begin word = {line_reg[7:0],   line_reg[15:8]};  letter = 8'h54; end
        endcase

        case (pos)
            5'd2:    nib = word[15:12];
            5'd3:    nib = word[11:8];
            5'd4:    nib = word[7:4];
            default: nib = word[3:0];
        endcase

        if (idx >= 5'd27) begin
            tx_char = (parm_crlf && (idx == 5'd27)) ? 8'h0D : 8'h0A;
        end else begin
            case (pos)
                5'd0:                   tx_char = letter;
                5'd1:                   tx_char = 8'h3A;
                5'd2, 5'd3, 5'd4, 5'd5: tx_char = {4'h0, nib} + ((nib < 4'd10) ? 8'h30 : 8'h37);
                default:                tx_char = 8'h20;
            endcase
        end
    end

    assign o_tx_byte    = (state == ST_SEND) ? tx_char : 8'h00;
    assign o_tx_valid   = (state == ST_SEND);
    assign o_busy       = (state != ST_IDLE);
    assign o_line_done  = (state == ST_DONE);
    assign o_drop_count = drop_count;

endmodule

// File: tb/tb_acl2_measurement_text_formatter.sv
// tb/tb_acl2_measurement_text_formatter.sv - scoreboard bench for the ACL2 text formatter
module tb_acl2_measurement_text_formatter;

    logic clk = 1'b0;
    always #25 clk = ~clk;

    logic        rst;
    logic [63:0] data, data0;
    logic        valid, valid0, ready, ready0;
    logic [7:0]  tx_byte, tx_byte0, drop, drop0;
    logic        tx_valid, tx_valid0, busy, busy0, line_done, line_done0;

    acl2_measurement_text_formatter #(.parm_crlf(1'b1)) dut (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst),
        .i_data_3axis_temp(data), .i_data_valid(valid),
        .o_tx_byte(tx_byte), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_busy(busy), .o_line_done(line_done), .o_drop_count(drop)
    );

    acl2_measurement_text_formatter #(.parm_crlf(1'b0)) dut0 (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst),
        .i_data_3axis_temp(data0), .i_data_valid(valid0),
        .o_tx_byte(tx_byte0), .o_tx_valid(tx_valid0), .i_tx_ready(ready0),
        .o_busy(busy0), .o_line_done(line_done0), .o_drop_count(drop0)
    );

    int asserts = 0;
    int fails = 0;
    logic [7:0] exp1[$];
    logic [7:0] exp0[$];
    int acc1 = 0, acc0 = 0, done1 = 0, done0 = 0;
    logic       stall1 = 1'b0, stall0 = 1'b0;
    logic [7:0] sb1 = 8'h00, sb0 = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string hx;
        hx = "0123456789ABCDEF";
        return hx[n];
    endfunction

    task automatic push_line(input logic [63:0] d, input bit crlf, input bit to0);
        logic [15:0] w[4];
        logic [7:0]  l[4];
        logic [7:0]  b[$];
        w[0] = {d[55:48], d[63:56]}; l[0] = "X";
        w[1] = {d[39:32], d[47:40]}; l[1] = "Y";
        w[2] = {d[23:16], d[31:24]}; l[2] = "Z";
        w[3] = {d[7:0],   d[15:8]};  l[3] = "T";
        for (int f = 0; f < 4; f++) begin
            b.push_back(l[f]);
            b.push_back(":");
            for (int k = 3; k >= 0; k--) b.push_back(hexc(w[f][k*4 +: 4]));
            if (f < 3) b.push_back(" ");
        end
        if (crlf) b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) begin
            if (to0) exp0.push_back(b[i]);
            else     exp1.push_back(b[i]);
        end
    endtask

    // Monitor: pops expected bytes on every handshake, checks stability during stalls.
    always @(negedge clk) begin
        if (rst) begin
            stall1 = 1'b0;
            stall0 = 1'b0;
        end else begin
            if (stall1) begin
                check("stall_valid", 64'(tx_valid), 64'd1);
                check("stall_byte", 64'(tx_byte), 64'(sb1));
            end
            if (tx_valid && ready) begin
                if (exp1.size() == 0) begin
                    asserts++; fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_byte);
                end else begin
                    check("byte", 64'(tx_byte), 64'(exp1.pop_front()));
                end
                acc1++;
            end
            stall1 = tx_valid && !ready;
            sb1 = tx_byte;
            if (line_done) done1++;

            if (stall0) begin
                check("stall_byte0", 64'(tx_byte0), 64'(sb0));
            end
            if (tx_valid0 && ready0) begin
                if (exp0.size() == 0) begin
                    asserts++; fails++;
                    $display("FAIL unexpected_byte0: got %0h expected none", tx_byte0);
                end else begin
                    check("byte0", 64'(tx_byte0), 64'(exp0.pop_front()));
                end
                acc0++;
            end
            stall0 = tx_valid0 && !ready0;
            sb0 = tx_byte0;
            if (line_done0) done0++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d);
        data = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        if (!rnd) ready = 1'b1;
        while ((busy || exp1.size() != 0) && n < 3000) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        ready = 1'b1;
        check("idle_timeout", 64'(n < 3000), 64'd1);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc1 < target && n < 200) begin
            step();
            n++;
        end
        check("acc_timeout", 64'(acc1 >= target), 64'd1);
    endtask

    initial begin
        int k, base, dbase;
        logic [63:0] d;
        rst = 1'b1; valid = 1'b0; valid0 = 1'b0; data = '0; data0 = '0;
        ready = 1'b1; ready0 = 1'b1;
        repeat (3) step();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_tx_valid0", 64'(tx_valid0), 64'd0);
        rst = 1'b0;
        step();

        // Single sample, timing of first byte and line_done
        push_line(64'h2301_F0FF_0004_1002, 1'b1, 1'b0);
        dbase = done1;
        send(64'h2301_F0FF_0004_1002);
        check("busy_n1", 64'(busy), 64'd1);
        check("tx_valid_n1", 64'(tx_valid), 64'd0);
        step();
        check("tx_valid_n2", 64'(tx_valid), 64'd1);
        check("first_byte_n2", 64'(tx_byte), 64'h58);
        k = 1;
        while (!line_done && k < 60) begin
            step();
            k++;
        end
        check("line_done_latency", 64'(k), 64'd30);
        check("drop_single", 64'(drop), 64'd0);
        step();
        check("busy_low_after_done", 64'(busy), 64'd0);
        check("queue_single", 64'(exp1.size()), 64'd0);
        check("done_single", 64'(done1 - dbase), 64'd1);

        // Backpressure with pseudo-random ready
        push_line(64'hABCD_1234_5678_9EF0, 1'b1, 1'b0);
        ready = 1'b0;
        send(64'hABCD_1234_5678_9EF0);
        wait_idle(1'b1);
        check("queue_bp", 64'(exp1.size()), 64'd0);

        // Mid-line samples: B overwritten by C, one drop
        dbase = done1;
        base = acc1;
        push_line(64'h0A00_0B00_0C00_0D00, 1'b1, 1'b0);
        send(64'h0A00_0B00_0C00_0D00);
        wait_acc(base + 5);
        send(64'hBBBB_BBBB_BBBB_BBBB);
        wait_acc(base + 10);
        push_line(64'h9876_5432_10FE_DCBA, 1'b1, 1'b0);
        send(64'h9876_5432_10FE_DCBA);
        wait_idle(1'b0);
        check("drop_mid", 64'(drop), 64'd1);
        check("done_mid", 64'(done1 - dbase), 64'd2);

        // Drop saturation under full stall
        ready = 1'b0;
        push_line(64'h5555_AAAA_0F0F_F0F0, 1'b1, 1'b0);
        send(64'h5555_AAAA_0F0F_F0F0);
        base = acc1;
        for (int i = 0; i < 300; i++) begin
            send(64'h1111_2222_3333_0000 | 64'(i));
            step();
        end
        check("drop_saturated", 64'(drop), 64'd255);
        check("stalled_no_bytes", 64'(acc1 - base), 64'd0);
        push_line(64'h1111_2222_3333_0000 | 64'd299, 1'b1, 1'b0);
        wait_idle(1'b0);
        check("drop_no_wrap", 64'(drop), 64'd255);

        // Reset during byte 12
        base = acc1;
        push_line(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0);
        send(64'hDEAD_BEEF_CAFE_F00D);
        wait_acc(base + 12);
        rst = 1'b1;
        step();
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_drop", 64'(drop), 64'd0);
        check("rst_mid_line_done", 64'(line_done), 64'd0);
        exp1.delete();
        rst = 1'b0;
        step();
        push_line(64'h0102_0304_0506_0708, 1'b1, 1'b0);
        send(64'h0102_0304_0506_0708);
        step();
        check("post_rst_first", 64'(tx_byte), 64'h58);
        wait_idle(1'b0);
        check("queue_post_rst", 64'(exp1.size()), 64'd0);

        // LF-only variant, all 0xFF
        dbase = done0;
        base = acc0;
        push_line({64{1'b1}}, 1'b0, 1'b1);
        data0 = {64{1'b1}};
        valid0 = 1'b1;
        step();
        valid0 = 1'b0;
        k = 0;
        while ((busy0 || exp0.size() != 0) && k < 200) begin
            step();
            k++;
        end
        check("lf_timeout", 64'(k < 200), 64'd1);
        check("lf_bytes", 64'(acc0 - base), 64'd28);
        check("lf_done_once", 64'(done0 - dbase), 64'd1);
        check("lf_drop", 64'(drop0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/acl2_measurement_text_formatter.md
# acl2_measurement_text_formatter

Downstream consumer of the PMOD ACL2 custom driver's 8-byte measurement snapshot (`o_data_3axis_temp` / `o_data_valid`). Each captured snapshot becomes one fixed-length ASCII hex text line: X, Y, Z, then temperature. The line is streamed byte-by-byte over a valid/ready handshake into the UART transmit stage. A one-deep pending buffer absorbs a sample that arrives mid-line, and a saturating counter records overwritten samples.

## Interface
- `parm_crlf`, default 1: 1 ends each line with CR LF (29 bytes); 0 ends with LF only (28 bytes).
- `i_clk_20mhz`  in  1  single system clock.
- `i_rst_20mhz`  in  1  reset, synchronous, active-high.
- `i_data_3axis_temp`  in  64 (`t_pmod_acl2_reg_8`)  snapshot.
  - [63:56] XDATA_L, [55:48] XDATA_H, [47:40] YDATA_L, [39:32] YDATA_H.
  - [31:24] ZDATA_L, [23:16] ZDATA_H, [15:8] TEMP_L, [7:0] TEMP_H.
- `i_data_valid`  in  1  one-cycle pulse qualifying `i_data_3axis_temp`.
- `o_tx_byte`  out  8  current ASCII character.
- `o_tx_valid`  out  1  `o_tx_byte` is valid.
- `i_tx_ready`  in  1  consumer accepts the byte when `o_tx_valid && i_tx_ready`.
- `o_busy`  out  1  high in any state other than ST_IDLE.
- `o_line_done`  out  1  one-cycle pulse after the last byte of a line is accepted.
- `o_drop_count`  out  8  saturating count of lost samples.

## Operation
- Field word = {H, L} byte pair, printed as 4 uppercase hex digits, MSB nibble first. No sign processing is done.
- Nibble encoding: 0-9 → 0x30+n; A-F → 0x37+n.
- Line format: `X:hhhh Y:hhhh Z:hhhh T:hhhh`, then CR LF (`parm_crlf`=1) or LF (`parm_crlf`=0).
- Line length L = 29 or 28 bytes. Character index counter is 5 bits and runs 0..L-1.
- States:
  - ST_IDLE: if `i_data_valid`, capture the input into the line register and go to ST_LOAD.
  - ST_LOAD: reset index to 0, go to ST_SEND.
  - ST_SEND: drive `o_tx_byte` from the index (combinational mux or registered, but it must be stable while `o_tx_valid` is high).
    - On handshake: if index == L-1, go to ST_DONE; otherwise increment index.
  - ST_DONE: pulse `o_line_done`.
    - If pending is full: copy pending into the line register, clear pending, go to ST_LOAD.
    - Otherwise go to ST_IDLE.
- Pending buffer:
  - Any `i_data_valid` outside ST_IDLE writes pending and sets pending-full.
  - If pending was already full and is not being consumed that cycle, the old pending value is overwritten and `o_drop_count` increments, saturating at 255.
  - In ST_DONE, a simultaneous `i_data_valid` and pending consumption: the consumed value goes to the line register, the new value becomes pending (full), and there is no drop.
- `o_tx_byte` and `o_tx_valid` must not change while `o_tx_valid && !i_tx_ready` (AXI-style stability).
- Illegal state encodings recover to ST_IDLE.

## Timing
- Reset values: `o_tx_byte`=0x00, `o_tx_valid`=0, `o_busy`=0, `o_line_done`=0, `o_drop_count`=0, pending empty, state ST_IDLE, index 0.
- `i_data_valid` in ST_IDLE at cycle N:
  - `o_busy`=1 from N+1.
  - `o_tx_valid`=1 with 'X' (0x58) at N+2.
- With `i_tx_ready` held high, one byte is transferred per cycle. Line N+2 .. N+2+L-1; `o_line_done` at N+2+L; `o_busy` low at N+3+L.
- Back-to-back lines from pending: first byte of the next line 2 cycles after `o_line_done` (ST_DONE → ST_LOAD → ST_SEND).
- `o_tx_valid` deasserts in ST_LOAD, ST_DONE and ST_IDLE.
- Reset asserted mid-line: the line is abandoned; on the next edge all outputs return to their reset values and pending is cleared.

## Test plan
- Single sample, `i_tx_ready`=1:
  - Input 64'h2301_F0FF_0004_1002 → 29 bytes "X:0123 Y:FFF0 Z:0400 T:0210" then 0x0D 0x0A.
  - First byte at N+2; `o_line_done` at N+31; `o_drop_count`=0.
- Backpressure: toggle `i_tx_ready` pseudo-randomly (≈50%) → identical byte sequence; `o_tx_byte` stable during every stall; no duplicated or skipped bytes.
- Mid-line samples:
  - Sample A starts a line; sample B arrives at byte 5 and sample C at byte 10 → line A completes, then line C is printed.
  - B is never printed; `o_drop_count`=1.
- Drop saturation: hold `i_tx_ready`=0 and pulse `i_data_valid` 300 times during one line → `o_drop_count`=255, no wrap to 0.
- Reset during byte 12 of a line → next cycle `o_tx_valid`=0, `o_busy`=0, counter 0; a new sample afterwards prints a full, correct line from 'X'.
- `parm_crlf`=0 with input all 0xFF → "X:FFFF Y:FFFF Z:FFFF T:FFFF" then 0x0A only; 28 bytes; `o_line_done` once.
